// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 pole-coefficient loader: FSM states,
// coefficient address map and the order in which words are shifted into the chain.
package biquad8_pkg;

    localparam int COEFF_W   = 18;
    localparam int NUM_COEFF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_A = 2'd0;
    localparam logic [1:0] ADDR_B = 2'd1;
    localparam logic [1:0] ADDR_C = 2'd2;
    localparam logic [1:0] ADDR_D = 2'd3;

    // D goes in first so that it travels furthest and ends up in DSP3; A ends in DSP0.
    function automatic logic [1:0] shift_addr(input logic [1:0] cnt);
        return ADDR_D - cnt;
    endfunction

endpackage

// File: rtl/biquad8_pole_coeff_loader.sv
// Loads four shadow coefficients serially into the pole IIR B-cascade, then
// pulses the update strobe so all four DSPs switch to the new values together.
module biquad8_pole_coeff_loader
    import biquad8_pkg::*;
#(
    parameter logic [17:0] INIT_A = 18'h00000,
    parameter logic [17:0] INIT_B = 18'h00000,
    parameter logic [17:0] INIT_C = 18'h00000,
    parameter logic [17:0] INIT_D = 18'h00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [17:0] cfg_dat_i,
    input  logic        cfg_commit_i,
    output logic [17:0] coeff_dat_o,
    output logic        coeff_wr_o,
    output logic        coeff_update_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [17:0] INIT_VALS [NUM_COEFF] = '{INIT_A, INIT_B, INIT_C, INIT_D};

    logic [17:0] shadow_reg [NUM_COEFF];
    logic [17:0] snap_reg   [NUM_COEFF];
    logic [17:0] fwd_val    [NUM_COEFF];
    logic [NUM_COEFF-1:0] wr_hit;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       pending_reg, pending_next;
    logic       capture;

    // A write landing in the capture cycle must be visible in the snapshot.
    for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_fwd
        assign wr_hit[gi]  = cfg_wr_i && (cfg_addr_i == 2'(gi));
        assign fwd_val[gi] = wr_hit[gi] ? cfg_dat_i : shadow_reg[gi];
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        capture      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_commit_i) begin
                    capture    = 1'b1;
                    cnt_next   = 2'd0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cfg_commit_i) begin
                    pending_next = 1'b1;
                end
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // A commit arriving in this very cycle restarts just like a pending one.
                if (pending_reg || cfg_commit_i) begin
                    capture      = 1'b1;
                    pending_next = 1'b0;
                    cnt_next     = 2'd0;
                    state_next   = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 2'd0;
            pending_reg <= 1'b0;
            for (int i = 0; i < NUM_COEFF; i++) begin
                shadow_reg[i] <= INIT_VALS[i];
                snap_reg[i]   <= '0;
            end
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            for (int i = 0; i < NUM_COEFF; i++) begin
                if (wr_hit[i]) begin
                    shadow_reg[i] <= cfg_dat_i;
                end
                if (capture) begin
                    snap_reg[i] <= fwd_val[i];
                end
            end
        end
    end

    // Outputs are gated by rst so the chain sees nothing in the reset cycle itself.
    always_comb begin
        coeff_wr_o     = !rst && (state_reg == ST_SHIFT);
        coeff_update_o = !rst && (state_reg == ST_UPDATE);
        done_o         = coeff_update_o;
        busy_o         = !rst && (state_reg != ST_IDLE);
        coeff_dat_o    = coeff_wr_o ? snap_reg[shift_addr(cnt_reg)] : 18'h00000;
    end

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a timeline-based reference model and a chained pole-IIR register model.
module tb_biquad8_pole_coeff_loader;
    import biquad8_pkg::*;

    localparam int MAXC  = 4096;
    localparam int RAND_END = 2600;
    localparam logic [17:0] IA = 18'd1, IB = 18'd2, IC = 18'd3, ID = 18'd4;

    logic        clk = 1'b0;
    logic        rst, cfg_wr_i, cfg_commit_i;
    logic [1:0]  cfg_addr_i;
    logic [17:0] cfg_dat_i;
    logic [17:0] coeff_dat_o;
    logic        coeff_wr_o, coeff_update_o, busy_o, done_o;

    always #5 clk = ~clk;

    biquad8_pole_coeff_loader #(
        .INIT_A(IA), .INIT_B(IB), .INIT_C(IC), .INIT_D(ID)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
        .cfg_dat_i(cfg_dat_i), .cfg_commit_i(cfg_commit_i), .coeff_dat_o(coeff_dat_o),
        .coeff_wr_o(coeff_wr_o), .coeff_update_o(coeff_update_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    // Expected output timeline, filled in when a sequence is launched.
    bit          exp_wr [MAXC];
    bit          exp_upd[MAXC];
    bit          exp_busy[MAXC];
    logic [17:0] exp_dat[MAXC];
    bit          obs_wr [MAXC];
    bit          obs_upd[MAXC];
    bit          obs_busy[MAXC];
    logic [17:0] obs_dat[MAXC];

    logic [17:0] m_shadow[4];
    int          seq_end = -1;
    bit          pend = 1'b0;
    logic [17:0] dsp_b1[4];
    logic [17:0] dsp_b2[4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input int at, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, at, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit w, input logic [1:0] a,
                        input logic [17:0] d, input bit cm);
        logic [17:0] snap[4];
        int order[4];
        bit start;
        order = '{int'(ADDR_D), int'(ADDR_C), int'(ADDR_B), int'(ADDR_A)};
        @(negedge clk);
        rst = r; cfg_wr_i = w; cfg_addr_i = a; cfg_dat_i = d; cfg_commit_i = cm;
        #1;
        check("coeff_wr",     cyc, 32'(coeff_wr_o),     32'(r ? 1'b0 : exp_wr[cyc]));
        check("coeff_dat",    cyc, 32'(coeff_dat_o),    32'(r ? 18'h0 : (exp_wr[cyc] ? exp_dat[cyc] : 18'h0)));
        check("coeff_update", cyc, 32'(coeff_update_o), 32'(r ? 1'b0 : exp_upd[cyc]));
        check("done",         cyc, 32'(done_o),         32'(r ? 1'b0 : exp_upd[cyc]));
        check("busy",         cyc, 32'(busy_o),         32'(r ? 1'b0 : exp_busy[cyc]));
        obs_wr[cyc] = coeff_wr_o; obs_upd[cyc] = coeff_update_o;
        obs_busy[cyc] = busy_o;   obs_dat[cyc] = coeff_dat_o;
        // Chained DSP model: head is DSP0, update copies B1 into B2.
        if (coeff_wr_o) begin
            for (int k = 3; k > 0; k--) dsp_b1[k] = dsp_b1[k-1];
            dsp_b1[0] = coeff_dat_o;
        end
        if (coeff_update_o) dsp_b2 = dsp_b1;
        if (r) begin
            for (int k = 1; k <= 6; k++) begin
                exp_wr[cyc+k] = 1'b0; exp_upd[cyc+k] = 1'b0; exp_busy[cyc+k] = 1'b0;
            end
            m_shadow = '{IA, IB, IC, ID};
            pend = 1'b0;
            seq_end = -1;
        end else begin
            for (int i = 0; i < 4; i++) snap[i] = (w && int'(a) == i) ? d : m_shadow[i];
            start = 1'b0;
            if (cyc > seq_end) begin
                start = cm;
            end else begin
                if (cm) pend = 1'b1;
                if (cyc == seq_end && pend) begin
                    pend = 1'b0;
                    start = 1'b1;
                end
            end
            if (start) begin
                for (int k = 0; k < 4; k++) begin
                    exp_wr[cyc+1+k]   = 1'b1;
                    exp_dat[cyc+1+k]  = snap[order[k]];
                    exp_busy[cyc+1+k] = 1'b1;
                end
                exp_upd[cyc+5]  = 1'b1;
                exp_busy[cyc+5] = 1'b1;
                seq_end = cyc + 5;
            end
            if (w) m_shadow[a] = d;
        end
        cyc++;
    endtask

    initial begin
        bit r, w, cm;
        logic [1:0] a;
        logic [17:0] d;
        int nwr, nupd;
        for (int i = 0; i < MAXC; i++) begin
            exp_wr[i] = 1'b0; exp_upd[i] = 1'b0; exp_busy[i] = 1'b0; exp_dat[i] = '0;
        end
        m_shadow = '{IA, IB, IC, ID};
        dsp_b1 = '{18'h0, 18'h0, 18'h0, 18'h0};
        dsp_b2 = '{18'h0, 18'h0, 18'h0, 18'h0};
        rst = 1'b1; cfg_wr_i = 1'b0; cfg_addr_i = 2'd0; cfg_dat_i = '0; cfg_commit_i = 1'b0;

        // Directed scenarios, one stimulus row per cycle.
        for (int c = 0; c < 110; c++) begin
            r  = (c < 3) || (c == 72);
            cm = (c == 10) || (c == 25) || (c == 35) || (c == 45) || (c == 48) ||
                 (c == 49) || (c == 70) || (c == 72) || (c == 82) || (c == 95) || (c == 100);
            w = 1'b1; a = ADDR_A; d = '0;
            case (c)
                21: begin a = ADDR_A; d = 18'h3FFFF; end
                22: begin a = ADDR_B; d = 18'h00100; end
                23: begin a = ADDR_C; d = 18'h20000; end
                24: begin a = ADDR_D; d = 18'h1FFFF; end
                35: begin a = ADDR_B; d = 18'h00005; end
                47: begin a = ADDR_A; d = 18'h00007; end
                72: begin a = ADDR_A; d = 18'h12345; end
                default: w = 1'b0;
            endcase
            tick(r, w, a, d, cm);
            if (c == 30) begin
                check("b2_dsp0_after_load", c, 32'(dsp_b2[0]), 32'h3FFFF);
                check("b2_dsp1_after_load", c, 32'(dsp_b2[1]), 32'h00100);
                check("b2_dsp2_after_load", c, 32'(dsp_b2[2]), 32'h20000);
                check("b2_dsp3_after_load", c, 32'(dsp_b2[3]), 32'h1FFFF);
            end
            if (c == 81) check("b2_dsp0_kept_on_abort", c, 32'(dsp_b2[0]), 32'h00007);
            if (c == 87) begin
                check("b2_dsp0_init", c, 32'(dsp_b2[0]), 32'd1);
                check("b2_dsp3_init", c, 32'(dsp_b2[3]), 32'd4);
            end
        end

        // Hand-computed literal expectations.
        check("reset_busy", 3, 32'(obs_busy[3]), 32'd0);
        check("reset_wr",   3, 32'(obs_wr[3]),   32'd0);
        for (int k = 0; k < 4; k++) begin
            check("init_word", 11 + k, 32'(obs_dat[11+k]), 32'(4 - k));
            check("init_wr",   11 + k, 32'(obs_wr[11+k]),  32'd1);
        end
        check("init_update", 15, 32'(obs_upd[15]),  32'd1);
        check("init_idle",   16, 32'(obs_busy[16]), 32'd0);
        check("word_D", 26, 32'(obs_dat[26]), 32'h1FFFF);
        check("word_C", 27, 32'(obs_dat[27]), 32'h20000);
        check("word_B", 28, 32'(obs_dat[28]), 32'h00100);
        check("word_A", 29, 32'(obs_dat[29]), 32'h3FFFF);
        check("fwd_B",  38, 32'(obs_dat[38]), 32'h00005);
        check("merge_old_A", 49, 32'(obs_dat[49]), 32'h3FFFF);
        check("merge_restart", 51, 32'(obs_wr[51]), 32'd1);
        check("merge_new_A", 54, 32'(obs_dat[54]), 32'h00007);
        nwr = 0; nupd = 0;
        for (int k = 46; k <= 64; k++) begin
            nwr += int'(obs_wr[k]);
            nupd += int'(obs_upd[k]);
        end
        check("merge_wr_count",  64, 32'(nwr),  32'd8);
        check("merge_upd_count", 64, 32'(nupd), 32'd2);
        nwr = 0; nupd = 0;
        for (int k = 73; k <= 82; k++) begin
            nwr += int'(obs_wr[k] | obs_busy[k] | obs_upd[k]);
            nupd += int'(obs_upd[k]);
        end
        check("abort_quiet",     82, 32'(nwr),  32'd0);
        check("abort_no_update", 82, 32'(nupd), 32'd0);
        check("post_reset_A", 86, 32'(obs_dat[86]), 32'd1);
        check("post_reset_update", 87, 32'(obs_upd[87]), 32'd1);
        check("update_commit_gapless", 101, 32'(obs_wr[101]), 32'd1);

        // Random traffic.
        while (cyc < RAND_END) begin
            r  = ($urandom_range(0, 99) < 2);
            w  = ($urandom_range(0, 99) < 30);
            cm = ($urandom_range(0, 99) < 12);
            a  = 2'($urandom_range(0, 3));
            d  = 18'($urandom);
            tick(r, w, a, d, cm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
